// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the I-cache line fill,
// the D-cache line fill and the D-cache dirty-line writeback.
//
// Whole-line bursts are serialised. Arbitration happens only in IDLE with fixed
// priority dc_wr_req > dc_rd_req > ic_req. An anti-starvation counter lets the
// I-cache win once STARVE_LIMIT consecutive D-cache grants have gone by while
// ic_req was pending.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ic_req/ic_addr/ic_gnt        I-cache read request, base address, accept pulse
//   ic_rvalid                    rd_data carries an I-cache beat
//   dc_rd_req/dc_rd_addr         D-cache read request and base address
//   dc_rd_gnt, dc_rvalid         D-cache accept pulse, D-cache read beat valid
//   rd_data, rd_last             shared read data (pass-through), final beat flag
//   dc_wr_req/dc_wr_addr         D-cache writeback request and base address
//   dc_wr_data, dc_wr_ready      writeback beat and its consume strobe
//   dc_wr_done                   one-cycle pulse after the last write beat
//   mem_addr                     latched base address of the active transaction
//   mem_rd_req/mem_rd_ack        read command handshake
//   mem_rd_valid/mem_rd_data     read beat from memory
//   mem_wr_req/mem_wr_data       write burst active, write beat to memory
//   mem_wr_ready                 memory accepts the write beat this cycle
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // I-cache fill
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    // D-cache fill
    input  logic                  dc_rd_req,
    input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
    output logic                  dc_rd_gnt,
    output logic                  dc_rvalid,
    // Shared read return
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    // D-cache writeback
    input  logic                  dc_wr_req,
    input  logic [ADDR_WIDTH-1:0] dc_wr_addr,
    input  logic [DATA_WIDTH-1:0] dc_wr_data,
    output logic                  dc_wr_ready,
    output logic                  dc_wr_done,
    // Memory controller
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_req,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ready
);

    localparam int unsigned BeatW   = $clog2(BURST_LEN);
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    localparam logic [BeatW-1:0]   BeatLast    = BeatW'(BURST_LEN - 1);
    localparam logic [StarveW-1:0] StarveLimit = StarveW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StRdCmd, StRdData, StWrData} state_e;
    typedef enum logic {OwnIc, OwnDc} owner_e;
    typedef enum logic [1:0] {WinNone, WinIc, WinDcRd, WinDcWr} win_e;

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [StarveW-1:0]      starve_q, starve_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    ic_gnt_q, ic_gnt_d;
    logic                    dc_rd_gnt_q, dc_rd_gnt_d;
    logic                    wr_done_q, wr_done_d;

    win_e                    win;
    logic                    rd_beat;
    logic                    wr_beat;

    // Arbitration winner for the current cycle; only acted upon in StIdle.
    always_comb begin
        win = WinNone;
        if (ic_req && (starve_q == StarveLimit)) begin
            win = WinIc;
        end else if (dc_wr_req) begin
            win = WinDcWr;
        end else if (dc_rd_req) begin
            win = WinDcRd;
        end else if (ic_req) begin
            win = WinIc;
        end
    end

    assign rd_beat = (state_q == StRdData) && mem_rd_valid;
    assign wr_beat = (state_q == StWrData) && mem_wr_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        beat_d      = beat_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        ic_gnt_d    = 1'b0;
        dc_rd_gnt_d = 1'b0;
        wr_done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                unique case (win)
                    WinIc: begin
                        state_d  = StRdCmd;
                        owner_d  = OwnIc;
                        addr_d   = ic_addr;
                        ic_gnt_d = 1'b1;
                    end
                    WinDcRd: begin
                        state_d     = StRdCmd;
                        owner_d     = OwnDc;
                        addr_d      = dc_rd_addr;
                        dc_rd_gnt_d = 1'b1;
                    end
                    WinDcWr: begin
                        state_d = StWrData;
                        owner_d = OwnDc;
                        addr_d  = dc_wr_addr;
                    end
                    default: ;
                endcase

                // Count D-cache grants that overtook a pending I-cache request.
                if (!ic_req || (win == WinIc)) begin
                    starve_d = '0;
                end else if (((win == WinDcRd) || (win == WinDcWr)) &&
                             (starve_q != StarveLimit)) begin
                    starve_d = starve_q + StarveW'(1);
                end
            end
            StRdCmd: begin
                if (mem_rd_ack) begin
                    state_d = StRdData;
                    beat_d  = '0;
                end
            end
            StRdData: begin
                if (mem_rd_valid) begin
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatLast) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrData: begin
                if (mem_wr_ready) begin
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatLast) begin
                        state_d   = StIdle;
                        wr_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnIc;
            beat_q      <= '0;
            starve_q    <= '0;
            addr_q      <= '0;
            ic_gnt_q    <= 1'b0;
            dc_rd_gnt_q <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            beat_q      <= beat_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            ic_gnt_q    <= ic_gnt_d;
            dc_rd_gnt_q <= dc_rd_gnt_d;
            wr_done_q   <= wr_done_d;
        end
    end

    always_comb begin
        ic_gnt      = ic_gnt_q;
        dc_rd_gnt   = dc_rd_gnt_q;
        dc_wr_done  = wr_done_q;
        mem_addr    = addr_q;
        mem_rd_req  = (state_q == StRdCmd);
        mem_wr_req  = (state_q == StWrData);
        mem_wr_data = dc_wr_data;
        dc_wr_ready = wr_beat;
        rd_data     = mem_rd_data;
        ic_rvalid   = rd_beat && (owner_q == OwnIc);
        dc_rvalid   = rd_beat && (owner_q == OwnDc);
        rd_last     = rd_beat && (beat_q == BeatLast);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for priority ordering, starvation and mid-burst reset.
module tb_mem_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;

    localparam logic [AW-1:0] IcAddr = 26'h0000100;
    localparam logic [AW-1:0] DcAddr = 26'h0000200;
    localparam logic [AW-1:0] WrAddr = 26'h0000300;

    // Output vector bit masks:
    // {ic_gnt, dc_rd_gnt, ic_rvalid, dc_rvalid, rd_last, dc_wr_ready, dc_wr_done,
    //  mem_rd_req, mem_wr_req}
    localparam logic [8:0] OIcg  = 9'b100000000;
    localparam logic [8:0] ODcg  = 9'b010000000;
    localparam logic [8:0] OIcv  = 9'b001000000;
    localparam logic [8:0] ODcv  = 9'b000100000;
    localparam logic [8:0] OLast = 9'b000010000;
    localparam logic [8:0] OWrdy = 9'b000001000;
    localparam logic [8:0] ODone = 9'b000000100;
    localparam logic [8:0] ORreq = 9'b000000010;
    localparam logic [8:0] OWreq = 9'b000000001;

    logic          clk;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_gnt;
    logic          ic_rvalid;
    logic          dc_rd_req;
    logic [AW-1:0] dc_rd_addr;
    logic          dc_rd_gnt;
    logic          dc_rvalid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          dc_wr_req;
    logic [AW-1:0] dc_wr_addr;
    logic [DW-1:0] dc_wr_data;
    logic          dc_wr_ready;
    logic          dc_wr_done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_req;
    logic          mem_rd_ack;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_req;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_ready;

    int checks;
    int errors;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BURST_LEN   (4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_gnt      (ic_gnt),
        .ic_rvalid   (ic_rvalid),
        .dc_rd_req   (dc_rd_req),
        .dc_rd_addr  (dc_rd_addr),
        .dc_rd_gnt   (dc_rd_gnt),
        .dc_rvalid   (dc_rvalid),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .dc_wr_req   (dc_wr_req),
        .dc_wr_addr  (dc_wr_addr),
        .dc_wr_data  (dc_wr_data),
        .dc_wr_ready (dc_wr_ready),
        .dc_wr_done  (dc_wr_done),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ready(mem_wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       ic;
        logic       dcr;
        logic       dcw;
        logic       ack;
        logic       vin;
        logic       wrdy;
        logic [7:0] data;
        logic [8:0] exp_out;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] outs();
        return {ic_gnt, dc_rd_gnt, ic_rvalid, dc_rvalid, rd_last, dc_wr_ready,
                dc_wr_done, mem_rd_req, mem_wr_req};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic ic, input logic dcr, input logic dcw,
                       input logic ack, input logic vin, input logic wrdy,
                       input logic [7:0] data, input logic [8:0] eo, input logic [AW-1:0] ea);
        vec_t v;
        v.rst = r; v.ic = ic; v.dcr = dcr; v.dcw = dcw; v.ack = ack; v.vin = vin;
        v.wrdy = wrdy; v.data = data; v.exp_out = eo; v.exp_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Enter in the RD_CMD (grant) cycle; leaves at the start of the following IDLE cycle.
    task automatic read_phase(input logic is_ic, input logic [AW-1:0] addr, input string tag);
        mem_rd_ack = 1'b1;
        @(negedge clk);
        chk({tag, "_ic_gnt"}, 32'(ic_gnt), 32'(is_ic));
        chk({tag, "_dc_gnt"}, 32'(dc_rd_gnt), 32'(!is_ic));
        chk({tag, "_rd_req"}, 32'(mem_rd_req), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        next_cycle();
        mem_rd_ack = 1'b0;
        if (is_ic) ic_req = 1'b0;
        else dc_rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hC0 + 32'(i);
            @(negedge clk);
            chk({tag, "_rvalid"}, {30'd0, ic_rvalid, dc_rvalid}, {30'd0, is_ic, !is_ic});
            chk({tag, "_last"}, 32'(rd_last), 32'(i == 3));
            chk({tag, "_data"}, rd_data, 32'hC0 + 32'(i));
            next_cycle();
        end
        mem_rd_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ic_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
        ic_addr = IcAddr; dc_rd_addr = DcAddr; dc_wr_addr = WrAddr;
        dc_wr_data = 32'h5A5A_0001; mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
        mem_rd_data = '0; mem_wr_ready = 1'b0;

        // ---- vector table ----
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 9'd0, 26'd0);              // reset state
        // I-cache read, ack at cycle 1, beats A0..A3
        add(0, 1, 0, 0, 0, 0, 0, 8'h00, 9'd0, 26'd0);
        add(0, 1, 0, 0, 1, 0, 0, 8'h00, OIcg | ORreq, IcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hA0, OIcv, IcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hA1, OIcv, IcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hA2, OIcv, IcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hA3, OIcv | OLast, IcAddr);
        // stray valid and ack while idle
        add(0, 0, 0, 0, 0, 1, 0, 8'h55, 9'd0, IcAddr);
        add(0, 0, 0, 0, 1, 0, 0, 8'h00, 9'd0, IcAddr);
        // D-cache read with ack delayed 10 cycles, stray valids in RD_CMD
        add(0, 0, 1, 0, 0, 0, 0, 8'h00, 9'd0, IcAddr);
        add(0, 0, 1, 0, 0, 1, 0, 8'h66, ODcg | ORreq, DcAddr);
        for (int i = 0; i < 9; i++) begin
            add(0, 0, 0, 0, 0, logic'(i % 2), 0, 8'h77, ORreq, DcAddr);
        end
        add(0, 0, 0, 0, 1, 0, 0, 8'h00, ORreq, DcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hB0, ODcv, DcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hB1, ODcv, DcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hB2, ODcv, DcAddr);
        add(0, 0, 0, 0, 0, 1, 0, 8'hB3, ODcv | OLast, DcAddr);
        // Writeback with mem_wr_ready 1,0,1,0,1,0,1
        add(0, 0, 0, 1, 0, 0, 0, 8'h00, 9'd0, DcAddr);
        for (int i = 0; i < 7; i++) begin
            add(0, 0, 0, 1, 0, 0, logic'(i % 2 == 0), 8'h00,
                OWreq | ((i % 2 == 0) ? OWrdy : 9'd0), WrAddr);
        end
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, ODone, WrAddr);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 9'd0, WrAddr);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; ic_req = vecs[i].ic; dc_rd_req = vecs[i].dcr;
            dc_wr_req = vecs[i].dcw; mem_rd_ack = vecs[i].ack;
            mem_rd_valid = vecs[i].vin; mem_wr_ready = vecs[i].wrdy;
            mem_rd_data = 32'(vecs[i].data);
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_rd_data", i), rd_data, 32'(vecs[i].data));
            next_cycle();
        end
        mem_rd_valid = 1'b0; mem_rd_ack = 1'b0; mem_wr_ready = 1'b0;

        // ---- all three requests at once: write, then D read, then I read ----
        ic_req = 1'b1; dc_rd_req = 1'b1; dc_wr_req = 1'b1;
        @(negedge clk);
        chk("prio_idle", 32'(outs()), 32'd0);
        next_cycle();
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dc_wr_data = 32'hD000 + 32'(i);
            @(negedge clk);
            chk("prio_wr_outs", 32'(outs()), 32'(OWreq | OWrdy));
            chk("prio_wr_data", mem_wr_data, 32'hD000 + 32'(i));
            if (i == 0) chk("prio_wr_addr", 32'(mem_addr), 32'(WrAddr));
            next_cycle();
        end
        dc_wr_req = 1'b0; mem_wr_ready = 1'b0;
        @(negedge clk);
        chk("prio_done", 32'(outs()), 32'(ODone));
        next_cycle();
        read_phase(1'b0, DcAddr, "prio_dc");
        @(negedge clk);
        chk("prio_gap", 32'(outs()), 32'd0);
        next_cycle();
        read_phase(1'b1, IcAddr, "prio_ic");

        // ---- starvation: four D grants then I wins ----
        ic_req = 1'b1;
        for (int g = 0; g < 5; g++) begin
            dc_rd_req = 1'b1;
            @(negedge clk);
            chk("starve_idle", 32'(mem_rd_req), 32'd0);
            next_cycle();
            read_phase(logic'(g == 4), (g == 4) ? IcAddr : DcAddr, "starve");
        end
        dc_rd_req = 1'b0; ic_req = 1'b0;
        @(negedge clk);
        chk("starve_cleared", 32'(dut.starve_q), 32'd0);
        next_cycle();

        // ---- reset during beat 2 of a read ----
        ic_req = 1'b1;
        next_cycle();
        mem_rd_ack = 1'b1;
        next_cycle();
        mem_rd_ack = 1'b0; ic_req = 1'b0;
        mem_rd_valid = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        dc_rd_req = 1'b1;
        next_cycle();
        read_phase(1'b0, DcAddr, "post_rst");
        @(negedge clk);
        chk("post_rst_idle", 32'(outs()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
